mult_div_unit: RTL and testbench



---
 rtl/mult_div_unit.sv | 176 +++++++++++++++++
 tb/tb_mult_div_unit.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit
//   Iterative HI/LO multiply/divide unit for the MIPS datapath.
//   Executes MULTU/MULT/DIVU/DIV over 32 iteration cycles plus one finish
//   cycle. The 64-bit result lands in HI/LO. MTHI/MTLO writes are accepted
//   only while the unit is idle.
//
// Ports
//   clk    : system clock, all state updates on posedge
//   rst    : asynchronous, active-high reset
//   start  : operation request, sampled only while idle
//   op     : 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   a, b   : operands (rs / rt)
//   hi_we  : MTHI write strobe (idle only)
//   lo_we  : MTLO write strobe (idle only)
//   wdata  : MTHI/MTLO write data
//   busy   : operation in flight
//   done   : one-cycle pulse, HI/LO (or dz) valid
//   dz     : divide-by-zero flag of the last divide, held until next start
//   hi, lo : architectural HI/LO registers
module mult_div_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             dz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FINISH
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    // Working register: multiply = {partial sum, remaining multiplier bits};
    // divide = {partial remainder, dividend bits shifting into quotient}.
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   bmag_q, bmag_d;
    logic [1:0]         op_q, op_d;
    logic               sa_q, sa_d;
    logic               sb_q, sb_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               dz_q, dz_d;

    logic [WIDTH-1:0]   amag, bmag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     rem_new;
    logic               rem_ge;
    logic [2*WIDTH-1:0] mul_next, div_next, prod_res;
    logic [WIDTH-1:0]   quo_res, rem_res;

    // Magnitudes only for signed ops; -2^31 maps to 2^31 as an unsigned value.
    assign amag = (op[0] && a[WIDTH-1]) ? -a : a;
    assign bmag = (op[0] && b[WIDTH-1]) ? -b : b;

    // Shift-add: conditionally add multiplicand into the upper half, then
    // shift the whole {carry, acc} right by one.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                    + (acc_q[0] ? {1'b0, bmag_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring divide: shift next dividend bit into the remainder, subtract
    // when it fits, shift the quotient bit in at the bottom.
    assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign rem_ge   = (rem_sh >= {1'b0, bmag_q});
    assign rem_new  = rem_ge ? (rem_sh - {1'b0, bmag_q}) : rem_sh;
    assign div_next = {rem_new[WIDTH-1:0], acc_q[WIDTH-2:0], rem_ge};

    // sa_q/sb_q are only ever set for signed ops, so no op check needed here.
    assign prod_res = (sa_q ^ sb_q) ? -acc_q : acc_q;
    assign quo_res  = (sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_res  = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        bmag_d  = bmag_q;
        op_d    = op_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        dz_d    = dz_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CALC;
                    cnt_d   = '0;
                    acc_d   = {{WIDTH{1'b0}}, amag};
                    bmag_d  = bmag;
                    op_d    = op;
                    sa_d    = op[0] & a[WIDTH-1];
                    sb_d    = op[0] & b[WIDTH-1];
                    dz_d    = 1'b0;
                end else begin
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                end
            end
            S_CALC: begin
                acc_d = op_q[1] ? div_next : mul_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == {CNT_W{1'b1}}) state_d = S_FINISH;
            end
            S_FINISH: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                if (op_q[1]) begin
                    if (bmag_q == '0) begin
                        dz_d = 1'b1;
                    end else begin
                        hi_d = rem_res;
                        lo_d = quo_res;
                    end
                end else begin
                    hi_d = prod_res[2*WIDTH-1:WIDTH];
                    lo_d = prod_res[WIDTH-1:0];
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            bmag_q  <= '0;
            op_q    <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            bmag_q  <= bmag_d;
            op_q    <= op_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign dz   = dz_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic [31:0] wdata = '0;
    logic        busy, done, dz;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;

    // Reference architectural state
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic        m_dz = 1'b0;

    // Edges from the start-sampling edge to the edge after which done is seen
    localparam int LAT = 33;

    always #5 clk = ~clk;

    mult_div_unit #(.WIDTH(32), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .dz(dz), .hi(hi), .lo(lo)
    );

    function automatic void model_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, sq, sr;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        m_dz = 1'b0;
        case (o)
            2'b00: begin p = {32'd0, x} * {32'd0, y}; m_hi = p[63:32]; m_lo = p[31:0]; end
            2'b01: begin p = sx * sy; m_hi = p[63:32]; m_lo = p[31:0]; end
            2'b10: if (y == 0) m_dz = 1'b1; else begin m_lo = x / y; m_hi = x % y; end
            default: if (y == 0) m_dz = 1'b1;
                     else begin
                         sq = sx / sy; sr = sx % sy;
                         p = sq; m_lo = p[31:0];
                         p = sr; m_hi = p[31:0];
                     end
        endcase
    endfunction

    task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // Scramble inputs: only latched copies may matter from here on
        op = 2'($urandom_range(3, 0)); a = $urandom; b = $urandom;
    endtask

    task automatic wait_done(output int lat, output bit busy_ok);
        lat = 0;
        busy_ok = 1'b1;
        while (lat < 100) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
            if (done === 1'b1) break;
        end
    endtask

    task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int lat, output bit busy_ok);
        start_op(o, x, y);
        model_op(o, x, y);
        wait_done(lat, busy_ok);
    endtask

    task automatic write_hilo(input logic hw, input logic lw, input logic [31:0] d);
        @(negedge clk);
        hi_we = hw; lo_we = lw; wdata = d;
        @(posedge clk); #1;
        hi_we = 1'b0; lo_we = 1'b0;
        if (hw) m_hi = d;
        if (lw) m_lo = d;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        checks++;
        if ({busy, done, dz, hi, lo} !== 67'd0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b dz=%b hi=%h lo=%h, required all 0", busy, done, dz, hi, lo);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b done=%b, required 0 0", busy, done);
        end
    endtask

    task automatic test_multu();
        int lat; bit bok;
        do_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bok);
        checks++;
        if (lat !== LAT) begin errors++; $display("FAIL multu_latency: got %0d edges, required %0d", lat, LAT); end
        checks++;
        if (bok !== 1'b1) begin errors++; $display("FAIL multu_busy: busy dropped before done"); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL multu_busy_at_done: got %b, required 0", busy); end
        checks++;
        if ({hi, lo} !== 64'hFFFFFFFE_00000001) begin
            errors++; $display("FAIL multu_result: hi=%h lo=%h, required fffffffe 00000001", hi, lo);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL done_pulse_width: done=%b one cycle later, required 0", done); end
    endtask

    task automatic test_mult();
        int lat; bit bok;
        do_op(2'b01, 32'hFFFFFFFD, 32'd7, lat, bok);
        checks++;
        if ({hi, lo, lat} !== {32'hFFFFFFFF, 32'hFFFFFFEB, LAT}) begin
            errors++; $display("FAIL mult_neg3x7: hi=%h lo=%h lat=%0d, required ffffffff ffffffeb %0d", hi, lo, lat, LAT);
        end
        do_op(2'b01, 32'h80000000, 32'h80000000, lat, bok);
        checks++;
        if ({hi, lo, lat} !== {32'h40000000, 32'h00000000, LAT}) begin
            errors++; $display("FAIL mult_min_sq: hi=%h lo=%h lat=%0d, required 40000000 00000000 %0d", hi, lo, lat, LAT);
        end
    endtask

    task automatic test_div();
        int lat; bit bok;
        do_op(2'b10, 32'd100, 32'd7, lat, bok);
        checks++;
        if ({hi, lo, dz} !== {32'd2, 32'd14, 1'b0}) begin
            errors++; $display("FAIL divu_100_7: hi=%h lo=%h dz=%b, required 2 14 0", hi, lo, dz);
        end
        do_op(2'b11, 32'hFFFFFFF9, 32'd2, lat, bok);
        checks++;
        if ({hi, lo, dz} !== {32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0}) begin
            errors++; $display("FAIL div_neg7_2: hi=%h lo=%h dz=%b, required ffffffff fffffffd 0", hi, lo, dz);
        end
        do_op(2'b11, 32'h80000000, 32'hFFFFFFFF, lat, bok);
        checks++;
        if ({hi, lo, dz, lat} !== {32'h0, 32'h80000000, 1'b0, LAT}) begin
            errors++; $display("FAIL div_min_neg1: hi=%h lo=%h dz=%b lat=%0d, required 0 80000000 0 %0d", hi, lo, dz, lat, LAT);
        end
    endtask

    task automatic test_div_zero();
        int lat; bit bok;
        write_hilo(1'b1, 1'b1, 32'h11111111);
        checks++;
        if ({hi, lo} !== {32'h11111111, 32'h11111111}) begin
            errors++; $display("FAIL mthi_mtlo: hi=%h lo=%h, required 11111111 11111111", hi, lo);
        end
        do_op(2'b10, 32'd5, 32'd0, lat, bok);
        checks++;
        if ({hi, lo, dz, lat} !== {32'h11111111, 32'h11111111, 1'b1, LAT}) begin
            errors++; $display("FAIL divu_by_zero: hi=%h lo=%h dz=%b lat=%0d, required 11111111 11111111 1 %0d", hi, lo, dz, lat, LAT);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (dz !== 1'b1) begin errors++; $display("FAIL dz_hold: dz=%b, required 1", dz); end
        start_op(2'b00, 32'd2, 32'd3);
        model_op(2'b00, 32'd2, 32'd3);
        checks++;
        if (dz !== 1'b0) begin errors++; $display("FAIL dz_clear_on_start: dz=%b, required 0", dz); end
        wait_done(lat, bok);
        checks++;
        if ({hi, lo} !== {32'd0, 32'd6}) begin
            errors++; $display("FAIL multu_2x3: hi=%h lo=%h, required 0 6", hi, lo);
        end
    endtask

    task automatic test_contention();
        int lat; bit bok;
        // Start while busy, plus MTHI/MTLO while busy: both ignored
        start_op(2'b00, 32'd1000, 32'd3);
        model_op(2'b00, 32'd1000, 32'd3);
        repeat (5) @(posedge clk);
        @(negedge clk);
        start = 1'b1; op = 2'b11; a = 32'hFFFF0000; b = 32'd5;
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEADBEEF;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        wait_done(lat, bok);
        checks++;
        if ({hi, lo, dz, lat + 6} !== {32'd0, 32'd3000, 1'b0, LAT}) begin
            errors++; $display("FAIL start_while_busy: hi=%h lo=%h dz=%b lat=%0d, required 0 bb8 0 %0d", hi, lo, dz, lat + 6, LAT);
        end
        // start and lo_we together in idle: start wins, write dropped
        @(negedge clk);
        start = 1'b1; op = 2'b10; a = 32'd9; b = 32'd0; lo_we = 1'b1; wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        start = 1'b0; lo_we = 1'b0;
        model_op(2'b10, 32'd9, 32'd0);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL start_over_lo_we_busy: busy=%b, required 1", busy); end
        wait_done(lat, bok);
        checks++;
        if ({hi, lo, dz} !== {m_hi, m_lo, 1'b1}) begin
            errors++; $display("FAIL start_over_lo_we: hi=%h lo=%h dz=%b, required %h %h 1", hi, lo, dz, m_hi, m_lo);
        end
        // start on the done cycle is accepted
        op = 2'b01; a = 32'hFFFFFFFD; b = 32'hFFFFFFF0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        model_op(2'b01, 32'hFFFFFFFD, 32'hFFFFFFF0);
        wait_done(lat, bok);
        checks++;
        if ({hi, lo, dz, lat} !== {32'd0, 32'd48, 1'b0, LAT}) begin
            errors++; $display("FAIL start_on_done: hi=%h lo=%h dz=%b lat=%0d, required 0 30 0 %0d", hi, lo, dz, lat, LAT);
        end
    endtask

    task automatic test_random();
        int lat; bit bok;
        logic [1:0] o;
        logic [31:0] x, y, d;
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(1, 0) == 1) begin
                d = $urandom;
                write_hilo(1'b1, 1'b1, d);
            end
            o = 2'($urandom_range(3, 0));
            x = (i % 5 == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(3, 0))
                0:       y = 32'd0;
                1:       y = $urandom_range(15, 1);
                2:       y = $urandom;
                default: y = 32'hFFFFFFFF;
            endcase
            do_op(o, x, y, lat, bok);
            checks++;
            if ({hi, lo, dz, lat, bok} !== {m_hi, m_lo, m_dz, LAT, 1'b1}) begin
                errors++;
                $display("FAIL random_%0d op=%0d a=%h b=%h: hi=%h lo=%h dz=%b lat=%0d busy_ok=%b, required %h %h %b %0d 1",
                         i, o, x, y, hi, lo, dz, lat, bok, m_hi, m_lo, m_dz, LAT);
            end
        end
    endtask

    task automatic test_async_reset();
        int lat; bit bok;
        write_hilo(1'b1, 1'b1, 32'h5A5A5A5A);
        start_op(2'b00, 32'h12345678, 32'h9ABCDEF0);
        repeat (10) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, dz, hi, lo} !== 67'd0) begin
            errors++; $display("FAIL async_reset: busy=%b done=%b dz=%b hi=%h lo=%h, required all 0", busy, done, dz, hi, lo);
        end
        @(negedge clk);
        rst = 1'b0;
        m_hi = '0; m_lo = '0; m_dz = 1'b0;
        do_op(2'b00, 32'd6, 32'd7, lat, bok);
        checks++;
        if ({hi, lo, lat, bok} !== {32'd0, 32'd42, LAT, 1'b1}) begin
            errors++; $display("FAIL multu_after_reset: hi=%h lo=%h lat=%0d busy_ok=%b, required 0 2a %0d 1", hi, lo, lat, bok, LAT);
        end
    endtask

    initial begin
        test_reset();
        test_multu();
        test_mult();
        test_div();
        test_div_zero();
        test_contention();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
